// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator (SLL, SRL, SRA, ROTL) moving at most MAX_STEP bits per clock.
// start/busy/done handshake; rd holds the last completed result.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for start; inputs latched on accept
//   S_SHIFT | acc moved by min(rem, MAX_STEP) each clock, rem counts down
//   S_DONE  | rd valid, one-cycle done pulse, back to idle next clock
module iter_shifter #(
    parameter int WIDTH    = 32,
    parameter int SHAMT_W  = 5,
    parameter int MAX_STEP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   rt,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   rd
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] STEP    = SHAMT_W'(MAX_STEP);
    localparam logic [SHAMT_W:0]   WIDTH_C = (SHAMT_W+1)'(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] rem;
    logic [1:0]         op_q;

    logic [SHAMT_W-1:0] amt;
    logic [SHAMT_W-1:0] rem_nxt;
    logic [SHAMT_W:0]   rot_back;
    logic [WIDTH-1:0]   shifted;
    logic               accept;

    assign accept   = (state == S_IDLE) && start;
    assign amt      = (rem < STEP) ? rem : STEP;
    assign rem_nxt  = rem - amt;
    assign rot_back = WIDTH_C - {1'b0, amt};

    // amt is never zero while shifting, so rot_back stays below WIDTH there
    always_comb begin
        shifted = acc;
        case (op_q)
            2'b00:   shifted = acc << amt;
            2'b01:   shifted = acc >> amt;
            2'b10:   shifted = WIDTH'($signed(acc) >>> amt);
            default: shifted = (acc << amt) | (acc >> rot_back);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (shamt == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                if (rem_nxt == '0) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            rem  <= '0;
            op_q <= '0;
            rd   <= '0;
        end else if (accept) begin
            acc  <= rt;
            rem  <= shamt;
            op_q <= op;
            if (shamt == '0) rd <= rt;
        end else if (state == S_SHIFT) begin
            acc <= shifted;
            rem <= rem_nxt;
            if (rem_nxt == '0) rd <= shifted;
        end
    end

    assign busy = (state == S_SHIFT) || (state == S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_iter_shifter.sv
// Directed-vector bench for iter_shifter: hand-computed table, full shamt sweep
// against a behavioural model, busy-time stimulus and mid-operation reset.
module tb_iter_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rt;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] rd;

    int n_cmp = 0;
    int n_err = 0;

    iter_shifter #(.WIDTH(32), .SHAMT_W(5), .MAX_STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .rt    (rt),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .rd    (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  shamt;
        logic [31:0] rt;
        logic [31:0] exp_rd;
        int          exp_n;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [4:0] s, input logic [31:0] r);
        logic [63:0] w;
        case (o)
            2'b00:   model = r << s;
            2'b01:   model = r >> s;
            2'b10:   begin w = {{32{r[31]}}, r} >> s; model = w[31:0]; end
            default: begin w = {r, r} << s; model = w[63:32]; end
        endcase
    endfunction

    // Issues one operation and returns rd and the number of edges from accept to done.
    // Inputs are scrambled after accept to confirm they were latched.
    task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] r,
                          output logic [31:0] got, output int lat);
        @(negedge clk);
        op = o; shamt = s; rt = r; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; shamt = ~s; rt = ~r;
        lat = 0;
        @(negedge clk);
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        got = rd;
        check("busy_with_done", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("busy_fall", {31'b0, busy}, 32'd0);
        check("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        int          lat;
        int          pulses;
        logic [31:0] base;

        base = 32'h805C9BD2;
        vecs[0]  = '{2'b00, 5'd4,  base,          32'h05C9BD20, 1};
        vecs[1]  = '{2'b01, 5'd8,  base,          32'h00805C9B, 2};
        vecs[2]  = '{2'b10, 5'd4,  base,          32'hF805C9BD, 1};
        vecs[3]  = '{2'b10, 5'd31, base,          32'hFFFFFFFF, 8};
        vecs[4]  = '{2'b11, 5'd4,  base,          32'h05C9BD28, 1};
        vecs[5]  = '{2'b00, 5'd0,  base,          32'h805C9BD2, 0};
        vecs[6]  = '{2'b01, 5'd0,  base,          32'h805C9BD2, 0};
        vecs[7]  = '{2'b10, 5'd0,  base,          32'h805C9BD2, 0};
        vecs[8]  = '{2'b11, 5'd0,  base,          32'h805C9BD2, 0};
        vecs[9]  = '{2'b01, 5'd31, base,          32'h00000001, 8};
        vecs[10] = '{2'b00, 5'd31, base,          32'h00000000, 8};
        vecs[11] = '{2'b11, 5'd31, base,          32'h402E4DE9, 8};
        vecs[12] = '{2'b10, 5'd5,  base,          32'hFC02E4DE, 2};
        vecs[13] = '{2'b00, 5'd1,  base,          32'h00B937A4, 1};
        vecs[14] = '{2'b01, 5'd1,  32'h12345678,  32'h091A2B3C, 1};
        vecs[15] = '{2'b11, 5'd16, base,          32'h9BD2805C, 4};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; rt = '0; shamt = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_rd", rd, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].shamt, vecs[i].rt, got, lat);
            check($sformatf("vec%0d_rd", i), got, vecs[i].exp_rd);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_n));
        end

        for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 32; s++) begin
                run_op(2'(o), 5'(s), base, got, lat);
                check($sformatf("sweep_op%0d_s%0d_rd", o, s), got, model(2'(o), 5'(s), base));
                check($sformatf("sweep_op%0d_s%0d_lat", o, s), 32'(lat), 32'((s + 3) / 4));
            end
        end

        // start while busy must be ignored and rt changes must not leak in
        @(negedge clk);
        op = 2'b00; shamt = 5'd16; rt = base; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        op = 2'b01; shamt = 5'd1; rt = 32'hFFFFFFFF; start = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                pulses++;
                start = 1'b0;
                check("busy_rd", rd, 32'h9BD20000);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_done_pulses", 32'(pulses), 32'd1);
        check("busy_second_ignored", {31'b0, busy}, 32'd0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        op = 2'b10; shamt = 5'd20; rt = base; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_rd", rd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);
        run_op(2'b00, 5'd1, base, got, lat);
        check("postrst_rd", got, 32'h00B937A4);
        check("postrst_lat", 32'(lat), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
